// File: rtl/lif_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_pkg : shared FSM encoding, timestep count and saturating add (rev 1.0)
// ---------------------------------------------------------------------------
package lif_pkg;

  localparam int LIF_TIMESTEPS = 4;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_FIRE   = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  // Operands arrive sign-extended to 32 bits; the result is clamped to the
  // signed range of 'width' bits and the caller truncates.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned width);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_update.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_neuron_update : one timestep of leak/integrate/compare/reset (rev 1.0)
// ---------------------------------------------------------------------------
module lif_neuron_update
  import lif_pkg::*;
#(
  parameter int ACC_WIDTH    = 14,
  parameter int MEM_WIDTH    = 16,
  parameter int THRESH_WIDTH = 15,
  parameter int LEAK_SHIFT   = 0
) (
  input  logic signed [MEM_WIDTH-1:0] v,
  input  logic signed [ACC_WIDTH-1:0] acc_t,
  input  logic [THRESH_WIDTH-1:0]     threshold,
  input  logic                        hard_mode,
  output logic signed [MEM_WIDTH-1:0] v_next,
  output logic                        spike
);

  logic signed [MEM_WIDTH-1:0] leak;
  logic signed [31:0]          v_int;
  logic signed [31:0]          thr_ext;

  assign leak = (LEAK_SHIFT == 0) ? '0 : (v >>> LEAK_SHIFT);

  always_comb begin
    // v - leak never leaves the MEM range, so only the integrate step saturates
    v_int   = sat_add(32'(v) - 32'(leak), 32'(acc_t), MEM_WIDTH);
    thr_ext = 32'(threshold);
    spike   = (v_int >= thr_ext);
    v_next  = MEM_WIDTH'(v_int);
    if (spike) begin
      v_next = hard_mode ? '0 : MEM_WIDTH'(v_int - thr_ext);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lif_spike_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_spike_gen : accumulates tppe partial sums and emits LIF spikes (rev 1.0)
// ---------------------------------------------------------------------------
module lif_spike_gen
  import lif_pkg::*;
#(
  parameter int TIMESTEPS    = LIF_TIMESTEPS,
  parameter int PSUM_WIDTH   = 10,
  parameter int ACC_WIDTH    = 14,
  parameter int MEM_WIDTH    = 16,
  parameter int THRESH_WIDTH = 15,
  parameter int LEAK_SHIFT   = 0,
  parameter int IDX_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PSUM_WIDTH-1:0]   psum_0,
  input  logic [PSUM_WIDTH-1:0]   psum_1,
  input  logic [PSUM_WIDTH-1:0]   psum_2,
  input  logic [PSUM_WIDTH-1:0]   psum_3,
  input  logic                    psum_valid,
  input  logic                    psum_last,
  output logic                    psum_ready,
  input  logic [THRESH_WIDTH-1:0] threshold,
  input  logic                    hard_reset_mode,
  output logic [TIMESTEPS-1:0]    spike_out,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic [IDX_WIDTH-1:0]    neuron_idx
);

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q   [TIMESTEPS];
  logic signed [ACC_WIDTH-1:0] acc_d   [TIMESTEPS];
  logic signed [ACC_WIDTH-1:0] acc_sum [TIMESTEPS];
  logic signed [PSUM_WIDTH-1:0] psum_arr [TIMESTEPS];
  logic signed [MEM_WIDTH-1:0] v_q, v_d, v_next;
  logic [1:0]                  t_q, t_d;
  logic [THRESH_WIDTH-1:0]     thr_q, thr_d;
  logic                        hard_q, hard_d;
  logic [TIMESTEPS-1:0]        spike_q, spike_d;
  logic [IDX_WIDTH-1:0]        idx_q, idx_d;
  logic                        spike_t;

  assign psum_arr[0] = psum_0;
  assign psum_arr[1] = psum_1;
  assign psum_arr[2] = psum_2;
  assign psum_arr[3] = psum_3;

  generate
    for (genvar g = 0; g < TIMESTEPS; g++) begin : g_acc
      assign acc_sum[g] = ACC_WIDTH'(sat_add(32'(acc_q[g]), 32'(psum_arr[g]), ACC_WIDTH));
    end
  endgenerate

  lif_neuron_update #(
    .ACC_WIDTH    (ACC_WIDTH),
    .MEM_WIDTH    (MEM_WIDTH),
    .THRESH_WIDTH (THRESH_WIDTH),
    .LEAK_SHIFT   (LEAK_SHIFT)
  ) u_update (
    .v         (v_q),
    .acc_t     (acc_q[t_q]),
    .threshold (thr_q),
    .hard_mode (hard_q),
    .v_next    (v_next),
    .spike     (spike_t)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    v_d     = v_q;
    t_d     = t_q;
    thr_d   = thr_q;
    hard_d  = hard_q;
    spike_d = spike_q;
    idx_d   = idx_q;
    case (state_q)
      ST_ACCUM: begin
        if (psum_valid) begin
          acc_d = acc_sum;
          if (psum_last) begin
            state_d = ST_FIRE;
            // A zero threshold would fire on every non-negative potential
            thr_d   = (threshold == '0) ? THRESH_WIDTH'(1) : threshold;
            hard_d  = hard_reset_mode;
            t_d     = 2'd0;
            v_d     = '0;
            spike_d = '0;
          end
        end
      end
      ST_FIRE: begin
        spike_d[t_q] = spike_t;
        v_d          = v_next;
        t_d          = t_q + 2'd1;
        if (t_q == 2'(TIMESTEPS - 1)) begin
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (spike_ready) begin
          for (int t = 0; t < TIMESTEPS; t++) begin
            acc_d[t] = '0;
          end
          idx_d   = idx_q + IDX_WIDTH'(1);
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      for (int t = 0; t < TIMESTEPS; t++) begin
        acc_q[t] <= '0;
      end
      v_q     <= '0;
      t_q     <= 2'd0;
      thr_q   <= THRESH_WIDTH'(1);
      hard_q  <= 1'b0;
      spike_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      v_q     <= v_d;
      t_q     <= t_d;
      thr_q   <= thr_d;
      hard_q  <= hard_d;
      spike_q <= spike_d;
      idx_q   <= idx_d;
    end
  end

  assign psum_ready  = (state_q == ST_ACCUM);
  assign spike_valid = (state_q == ST_OUTPUT);
  assign spike_out   = spike_q;
  assign neuron_idx  = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_spike_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lif_spike_gen : scoreboard bench for lif_spike_gen (rev 1.0)
// ---------------------------------------------------------------------------
module tb_lif_spike_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  psum_0 = '0, psum_1 = '0, psum_2 = '0, psum_3 = '0;
  logic        psum_valid = 1'b0;
  logic        psum_last = 1'b0;
  logic        psum_ready;
  logic [14:0] threshold = 15'd8;
  logic        hard_reset_mode = 1'b0;
  logic [3:0]  spike_out;
  logic        spike_valid;
  logic        spike_ready = 1'b1;
  logic [7:0]  neuron_idx;

  lif_spike_gen dut (
    .clk             (clk),
    .rst             (rst),
    .psum_0          (psum_0),
    .psum_1          (psum_1),
    .psum_2          (psum_2),
    .psum_3          (psum_3),
    .psum_valid      (psum_valid),
    .psum_last       (psum_last),
    .psum_ready      (psum_ready),
    .threshold       (threshold),
    .hard_reset_mode (hard_reset_mode),
    .spike_out       (spike_out),
    .spike_valid     (spike_valid),
    .spike_ready     (spike_ready),
    .neuron_idx      (neuron_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] spk;
    logic [7:0] idx;
    int         vcyc;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         model_acc[4] = '{0, 0, 0, 0};
  logic [7:0] model_idx = '0;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clamp(input int x, input int lo, input int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic [3:0] model_fire(input int thr_in, input bit hard);
    int         v;
    int         thr;
    logic [3:0] s;
    thr = (thr_in == 0) ? 1 : thr_in;
    v   = 0;
    s   = '0;
    for (int t = 0; t < 4; t++) begin
      v = clamp(v + model_acc[t], -32768, 32767);
      if (v >= thr) begin
        s[t] = 1'b1;
        v    = hard ? 0 : v - thr;
      end
    end
    return s;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input int p0, input int p1, input int p2, input int p3, input bit last);
    bit   ok;
    int   acc_cyc;
    int   p[4];
    exp_t e;
    p = '{p0, p1, p2, p3};
    psum_0 = 10'(p0); psum_1 = 10'(p1); psum_2 = 10'(p2); psum_3 = 10'(p3);
    psum_valid = 1'b1;
    psum_last  = last;
    ok = 1'b0;
    acc_cyc = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok      = psum_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    chk("beat_accept", 32'(ok), 32'd1);
    if (ok) begin
      for (int t = 0; t < 4; t++) model_acc[t] = clamp(model_acc[t] + p[t], -8192, 8191);
      if (last) begin
        e.spk  = model_fire(int'(threshold), hard_reset_mode);
        e.idx  = model_idx;
        e.vcyc = acc_cyc + 5;
        sb.push_back(e);
        model_idx++;
        model_acc = '{0, 0, 0, 0};
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic int rnd_psum();
    int r;
    r = int'($urandom_range(0, 1023));
    return (r > 511) ? r - 1024 : r;
  endfunction

  always @(negedge clk) begin
    if (!rst && spike_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(spike_valid), 32'd0);
      end else begin
        if (!prev_valid) chk("latency", 32'(cyc), 32'(sb[0].vcyc));
        chk("spike_out", 32'(spike_out), 32'(sb[0].spk));
        chk("neuron_idx", 32'(neuron_idx), 32'(sb[0].idx));
        chk("psum_ready_in_output", 32'(psum_ready), 32'd0);
        if (spike_ready) void'(sb.pop_front());
      end
    end
    prev_valid = spike_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_psum_ready", 32'(psum_ready), 32'd1);
    chk("rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("rst_neuron_idx", 32'(neuron_idx), 32'd0);
    chk("rst_spike_out", 32'(spike_out), 32'd0);
    @(posedge clk); #1;

    // Soft mode, threshold changed mid-FIRE must be ignored
    threshold = 15'd8; hard_reset_mode = 1'b0;
    send_beat(5, 10, 3, 12, 1'b1);
    threshold = 15'd1;
    wait_idle();

    // Two K-tile beats
    threshold = 15'd8;
    send_beat(3, 3, 3, 3, 1'b0);
    send_beat(4, 4, 4, 4, 1'b1);
    wait_idle();

    // Hard reset mode
    hard_reset_mode = 1'b1;
    send_beat(5, 10, 3, 12, 1'b1);
    wait_idle();

    // Negative drive never fires
    hard_reset_mode = 1'b0;
    send_beat(-20, 5, 5, 5, 1'b1);
    wait_idle();

    // Backpressure held in OUTPUT, then the following neuron
    spike_ready = 1'b0;
    send_beat(9, 0, 8, 20, 1'b1);
    repeat (12) @(posedge clk);
    #1 spike_ready = 1'b1;
    wait_idle();
    send_beat(1, 2, 3, 4, 1'b1);
    wait_idle();

    // Accumulator saturation
    threshold = 15'd1000;
    for (int i = 0; i < 20; i++) send_beat(511, 511, 511, 511, i == 19);
    wait_idle();

    // Random neurons, long enough to wrap the index
    for (int i = 0; i < 256; i++) begin
      int nb;
      threshold       = (i == 0) ? 15'd0 : 15'($urandom_range(1, 200));
      hard_reset_mode = 1'($urandom_range(0, 1));
      nb = int'($urandom_range(1, 2));
      for (int b = 0; b < nb; b++) send_beat(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum(), b == nb - 1);
    end
    wait_idle();

    // Reset in the middle of FIRE
    threshold = 15'd8; hard_reset_mode = 1'b0;
    send_beat(5, 10, 3, 12, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    model_idx = '0;
    model_acc = '{0, 0, 0, 0};
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midfire_rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("midfire_rst_psum_ready", 32'(psum_ready), 32'd1);
    chk("midfire_rst_neuron_idx", 32'(neuron_idx), 32'd0);
    @(posedge clk); #1;
    send_beat(5, 10, 3, 12, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
